// File: rtl/pc_sequencer_if.sv
// pc_sequencer_if: groups the pipeline-facing signals of the next-PC unit.
//   master modport: pipeline side (drives ID/EX info and stall, sees PC,
//                   prediction and flush outputs)
//   slave modport : pc_sequencer side
// Parameter ADDR_W sets the PC/address width.
interface pc_sequencer_if #(
    parameter int unsigned ADDR_W = 32
);
    // Hazard control
    logic              stall;
    // ID stage
    logic [ADDR_W-1:0] id_pc4;
    logic              id_jump;
    logic              id_link;
    logic [25:0]       id_jump_addr;
    logic              id_ret;
    // EX stage
    logic [ADDR_W-1:0] ex_pc4;
    logic [ADDR_W-1:0] ex_imm;
    logic [1:0]        ex_branch;
    logic              ex_zero;
    logic              ex_jr;
    logic [ADDR_W-1:0] ex_jr_target;
    logic              ex_jr_pred;
    logic [ADDR_W-1:0] ex_jr_pred_target;
    // Outputs of the sequencer
    logic [ADDR_W-1:0] pc;
    logic [ADDR_W-1:0] pc4;
    logic              ras_pred_valid;
    logic [ADDR_W-1:0] ras_pred_target;
    logic              flush_if_id;
    logic              flush_id_ex;
    logic              misalign_err;

    modport master (
        output stall,
        output id_pc4, id_jump, id_link, id_jump_addr, id_ret,
        output ex_pc4, ex_imm, ex_branch, ex_zero,
        output ex_jr, ex_jr_target, ex_jr_pred, ex_jr_pred_target,
        input  pc, pc4, ras_pred_valid, ras_pred_target,
        input  flush_if_id, flush_id_ex, misalign_err
    );

    modport slave (
        input  stall,
        input  id_pc4, id_jump, id_link, id_jump_addr, id_ret,
        input  ex_pc4, ex_imm, ex_branch, ex_zero,
        input  ex_jr, ex_jr_target, ex_jr_pred, ex_jr_pred_target,
        output pc, pc4, ras_pred_valid, ras_pred_target,
        output flush_if_id, flush_id_ex, misalign_err
    );
endinterface

// File: rtl/pc_sequencer.sv
// pc_sequencer: registered next-PC unit for a 5-stage MIPS pipeline.
// Owns the PC register and picks the next fetch address with priority
// EX branch > EX JR correction > ID jump > ID RAS-predicted return >
// stall hold > sequential. Produces same-cycle flush requests and keeps a
// circular return-address stack (RAS) that predicts JR $31 in ID.
// Ports:
//   clk  - clock
//   rst  - synchronous active-high reset
//   bus  - pc_sequencer_if.slave (stall, ID/EX inputs; pc, pc4,
//          ras_pred_valid/target, flush_if_id/id_ex, misalign_err)
// Optional build macro: PC_SEQ_ALIGN_CHECK_EN
//   defined   - redirect targets with bits[1:0]!=0 raise misalign_err for
//               one cycle and the loaded PC is forced word-aligned
//   undefined - misalign_err tied to 0, targets loaded unmodified
module pc_sequencer #(
    parameter int unsigned          ADDR_W    = 32,
    parameter logic [ADDR_W-1:0]    RESET_PC  = '0,
    parameter int unsigned          RAS_DEPTH = 4
) (
    input  logic               clk,
    input  logic               rst,
    pc_sequencer_if.slave      bus
);

    localparam int unsigned PTR_W = (RAS_DEPTH > 1) ? $clog2(RAS_DEPTH) : 1;
    localparam int unsigned CNT_W = $clog2(RAS_DEPTH + 1);
    // Upper PC bits kept by a J-type target (region select)
    localparam logic [ADDR_W-1:0] J_KEEP_MASK = ~ADDR_W'(28'hFFF_FFFF);

    logic [ADDR_W-1:0] pc_q, pc_d;
    logic [ADDR_W-1:0] pc4_c;
    logic [PTR_W-1:0]  ptr_q, ptr_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic [ADDR_W-1:0] ras_q [RAS_DEPTH];

    logic [ADDR_W-1:0] br_t, j_t, jr_t, ras_top, sel_t;
    logic [PTR_W-1:0]  top_idx;
    logic              ras_empty;
    logic              br_taken, jr_fix, ex_redir, id_ok;
    logic              id_jump_go, pred_go, push_go;
    logic              ras_we;
    logic [PTR_W-1:0]  ras_waddr;

    // Sequential address
    assign pc4_c = pc_q + ADDR_W'(4);

    // Redirect targets and RAS top-of-stack
    always_comb begin
        br_t      = bus.ex_pc4 + {bus.ex_imm[ADDR_W-3:0], 2'b00};
        j_t       = (bus.id_pc4 & J_KEEP_MASK) | ADDR_W'({bus.id_jump_addr, 2'b00});
        jr_t      = bus.ex_jr_target;
        ras_empty = (cnt_q == '0);
        top_idx   = ptr_q - PTR_W'(1);
        ras_top   = ras_empty ? '0 : ras_q[top_idx];
    end

    // Redirect conditions; any EX redirect or stall kills ID-stage actions
    always_comb begin
        br_taken   = bus.ex_branch[1] & (bus.ex_branch[0] ? bus.ex_zero : ~bus.ex_zero);
        jr_fix     = bus.ex_jr & (~bus.ex_jr_pred | (bus.ex_jr_pred_target != bus.ex_jr_target));
        ex_redir   = br_taken | jr_fix;
        id_ok      = ~bus.stall & ~ex_redir;
        id_jump_go = bus.id_jump & id_ok;
        pred_go    = bus.id_ret & ~ras_empty & id_ok;
        push_go    = bus.id_link & id_ok;
    end

    // Next-PC priority select (branch also wins over a simultaneous JR)
    always_comb begin
        sel_t = pc4_c;
        if (br_taken) begin
            sel_t = br_t;
        end else if (jr_fix) begin
            sel_t = jr_t;
        end else if (id_jump_go) begin
            sel_t = j_t;
        end else if (pred_go) begin
            sel_t = ras_top;
        end else if (bus.stall) begin
            sel_t = pc_q;
        end
    end

`ifdef PC_SEQ_ALIGN_CHECK_EN
    logic misalign_q, misalign_d;
    logic redir_sel;

    // Flag unaligned redirects and word-align whatever gets loaded
    always_comb begin
        redir_sel  = br_taken | jr_fix | id_jump_go | pred_go;
        misalign_d = redir_sel & (sel_t[1:0] != 2'b00);
        pc_d       = {sel_t[ADDR_W-1:2], 2'b00};
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            misalign_q <= 1'b0;
        end else begin
            misalign_q <= misalign_d;
        end
    end

    assign bus.misalign_err = misalign_q;
`else
    assign pc_d             = sel_t;
    assign bus.misalign_err = 1'b0;
`endif

    // RAS pointer/count update; pop+push in one cycle replaces the top entry
    always_comb begin
        ptr_d     = ptr_q;
        cnt_d     = cnt_q;
        ras_we    = 1'b0;
        ras_waddr = ptr_q;
        if (pred_go && push_go) begin
            ras_we    = 1'b1;
            ras_waddr = top_idx;
        end else if (pred_go) begin
            ptr_d = top_idx;
            cnt_d = cnt_q - CNT_W'(1);
        end else if (push_go) begin
            ras_we = 1'b1;
            ptr_d  = ptr_q + PTR_W'(1);
            if (cnt_q != CNT_W'(RAS_DEPTH)) begin
                cnt_d = cnt_q + CNT_W'(1);
            end
        end
    end

    // PC and RAS control state
    always_ff @(posedge clk) begin
        if (rst) begin
            pc_q  <= RESET_PC;
            ptr_q <= '0;
            cnt_q <= '0;
        end else begin
            pc_q  <= pc_d;
            ptr_q <= ptr_d;
            cnt_q <= cnt_d;
        end
    end

    // RAS storage; contents are don't-care while count is zero
    always_ff @(posedge clk) begin
        if (ras_we && !rst) begin
            ras_q[ras_waddr] <= bus.id_pc4;
        end
    end

    // Outputs; flush/prediction forced low during reset
    assign bus.pc              = pc_q;
    assign bus.pc4             = pc4_c;
    assign bus.flush_if_id     = ~rst & (ex_redir | id_jump_go | pred_go);
    assign bus.flush_id_ex     = ~rst & ex_redir;
    assign bus.ras_pred_valid  = ~rst & pred_go;
    assign bus.ras_pred_target = rst ? '0 : ras_top;

endmodule

// File: doc/pc_sequencer.md
Name: pc_sequencer

Overview:
Registered next-PC unit for the 5-stage MIPS pipeline. It owns the PC register and arbitrates between sequential fetch, the ID-stage jump, the EX-stage branch and the EX-stage JR. It replaces delay-buffered PC selection with clocked, priority-encoded redirects and pipeline flush outputs. A parametrised return-address stack (RAS) predicts JR $31 in ID; the EX stage corrects the fetch when that prediction is wrong.

Parameters:
ADDR_W, 32, PC/address width (>=28)
RESET_PC, 0, PC value loaded on reset
RAS_DEPTH, 4, return-address stack entries (power of 2, >=2)

Ports:
clk  in  1  clock
rst  in  1  synchronous active-high reset
stall  in  1  hazard-unit stall; holds PC and suppresses ID-stage actions
id_pc4  in  ADDR_W  PC+4 of the instruction in ID
id_jump  in  1  J/JAL decoded in ID
id_link  in  1  JAL in ID (push id_pc4 onto RAS)
id_jump_addr  in  26  instr[25:0]
id_ret  in  1  JR $31 decoded in ID (RAS predict candidate)
ex_pc4  in  ADDR_W  PC+4 of the instruction in EX
ex_imm  in  ADDR_W  sign-extended immediate
ex_branch  in  2  [1]=branch, [0]=1 BEQ / 0 BNE
ex_zero  in  1  ALU zero flag
ex_jr  in  1  JR in EX
ex_jr_target  in  ADDR_W  forwarded rs value
ex_jr_pred  in  1  the JR in EX was RAS-predicted in ID
ex_jr_pred_target  in  ADDR_W  target predicted in ID (piped back)
pc  out  ADDR_W  registered fetch PC
pc4  out  ADDR_W  pc+4 (combinational)
ras_pred_valid  out  1  ID JR $31 redirected by RAS this cycle
ras_pred_target  out  ADDR_W  RAS top-of-stack
flush_if_id  out  1  kill the IF/ID register
flush_id_ex  out  1  kill the ID/EX register
misalign_err  out  1  see Optional Feature

Behaviour:
- Reset: pc=RESET_PC; RAS count=0, pointer=0; misalign_err=0. All flush and prediction outputs are 0 while rst=1.
- Targets, all modulo 2^ADDR_W:
  - br_t = ex_pc4 + (ex_imm<<2)
  - j_t = {id_pc4[ADDR_W-1:28], id_jump_addr, 2'b00}
  - jr_t = ex_jr_target
- Conditions:
  - br_taken = ex_branch[1] & (ex_branch[0] ? ex_zero : ~ex_zero)
  - jr_fix = ex_jr & (~ex_jr_pred | ex_jr_pred_target != ex_jr_target)
  - ex_redir = br_taken | jr_fix
- Next-PC priority, registered on the next clk edge (one-cycle latency):
  1. br_taken -> br_t
  2. jr_fix -> jr_t
  3. id_jump & ~stall -> j_t
  4. id_ret & ~stall & RAS non-empty -> ras_pred_target
  5. stall -> hold pc
  6. otherwise -> pc4
- EX redirects override stall. br_taken and ex_jr asserted together: branch wins; count as a decoder error.
- Flush outputs (combinational, same cycle as the decision):
  - ex_redir -> flush_if_id=1, flush_id_ex=1
  - ID jump or RAS-predicted ID return, with no ex_redir -> flush_if_id=1 only
- ID-stage actions (jump, push, pop, prediction) are suppressed when ex_redir=1 or stall=1.
- ras_pred_valid = id_ret & RAS non-empty & ~stall & ~ex_redir.
- RAS is a circular buffer; all updates on clk:
  - Push (id_link): write id_pc4 at ptr, ptr+1 mod RAS_DEPTH, count saturates at RAS_DEPTH. Push when full overwrites the oldest entry.
  - Pop (ras_pred_valid): ptr-1, count-1. Pop when empty is impossible because prediction is gated by non-empty; the ID JR then falls through to EX resolution.
  - id_link and id_ret asserted together: pop first, then push (net ptr unchanged, top replaced).
  - ras_pred_target = entry[ptr-1], or 0 when empty.
- RAS is not repaired on mispredict. jr_fix only corrects the PC.
- Reset mid-operation: all state returns to reset values on that edge; any in-flight redirect is discarded.

Optional Feature:
PC_SEQ_ALIGN_CHECK_EN
- Defined:
  - Any selected redirect target with bits[1:0]!=0 sets misalign_err for one cycle, registered alongside pc.
  - The loaded pc has bits[1:0] forced to 00.
- Undefined: misalign_err is tied to 0 and targets are loaded unmodified.

Test Plan:
- Reset with RESET_PC=32'h0040_0000, then 3 free-running cycles -> pc = 00400000, 00400004, 00400008, 0040000C; no flush outputs asserted.
- ex_pc4=100, ex_imm=-2, BEQ with ex_zero=1, stall=1 in the same cycle -> next pc=F8, flush_if_id=1, flush_id_ex=1; stall is overridden.
- id_jump with id_pc4=00400010, addr=26'h0000100 and a concurrent BNE not taken -> next pc=00000400 and flush_if_id=1 only. Repeat with BNE taken -> the branch target wins.
- 5 JALs pushing 10, 20, 30, 40, 50 into RAS_DEPTH=4, then 4 id_ret -> predictions 50, 40, 30, 20. A 5th id_ret gives ras_pred_valid=0 and the PC falls to pc4.
- Predicted return to 40 with ex_jr_target=44 in EX -> jr_fix, next pc=44, both flushes asserted. Matching target -> no redirect.
- With PC_SEQ_ALIGN_CHECK_EN, JR to 00000102 -> pc=00000100 and misalign_err=1 for one cycle.
